// File: rtl/sn_api_arbiter.sv
// API bus arbiter: grants one pending source per cycle during a transmit phase.
// Define SN_API_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index first).
module sn_api_arbiter #(
  parameter int P_NUM_NEURONS = 100,
  parameter int P_NUM_OUTPUTS = 3,
  parameter int P_NUM_SRC     = P_NUM_NEURONS - P_NUM_OUTPUTS,
  parameter int P_API_BUS_BW  = $clog2(P_NUM_SRC + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    nc_reset,
  input  logic                    nc_transmit,
  input  logic [P_NUM_SRC-1:0]    api_pending,
  output logic [P_NUM_SRC-1:0]    api_granted,
  output logic                    api_vld,
  output logic [P_API_BUS_BW-1:0] api_bus,
  output logic                    api_busy,
  output logic                    api_done,
  output logic [P_API_BUS_BW-1:0] api_tx_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: a source holds api_pending until it sees its api_granted bit,
  // then drops it one edge later; the arbiter masks the last grant for that edge.

  state_t                  state_q, state_d;
  logic [P_NUM_SRC-1:0]    granted_q, granted_d;
  logic                    vld_q, vld_d;
  logic [P_API_BUS_BW-1:0] bus_q, bus_d;
  logic [P_API_BUS_BW-1:0] cnt_q, cnt_d;

  logic [P_NUM_SRC-1:0]    eligible;
  logic                    found;
  logic [P_API_BUS_BW-1:0] pick;
  logic [P_NUM_SRC-1:0]    pick_oh;
  logic                    found_lo;
  logic [P_API_BUS_BW-1:0] pick_lo;
  logic [P_NUM_SRC-1:0]    oh_lo;
  logic [P_API_BUS_BW-1:0] pick_inc;

`ifdef SN_API_ARB_ROUND_ROBIN_EN
  logic [P_API_BUS_BW-1:0] rr_q, rr_d;
  logic                    found_hi;
  logic [P_API_BUS_BW-1:0] pick_hi;
  logic [P_NUM_SRC-1:0]    oh_hi;
`endif

  // Round-robin: first eligible at or above rr_ptr, else wrap to the lowest eligible.
  always_comb begin
    eligible = api_pending & ~granted_q;
    found_lo = 1'b0;
    pick_lo  = '0;
    oh_lo    = '0;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
    found_hi = 1'b0;
    pick_hi  = '0;
    oh_hi    = '0;
`endif
    for (int k = 0; k < P_NUM_SRC; k++) begin
      if (eligible[k] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = P_API_BUS_BW'(k);
        oh_lo[k] = 1'b1;
      end
`ifdef SN_API_ARB_ROUND_ROBIN_EN
      if (eligible[k] && !found_hi && (P_API_BUS_BW'(k) >= rr_q)) begin
        found_hi = 1'b1;
        pick_hi  = P_API_BUS_BW'(k);
        oh_hi[k] = 1'b1;
      end
`endif
    end
    found   = found_lo;
    pick    = pick_lo;
    pick_oh = oh_lo;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
    if (found_hi) begin
      pick    = pick_hi;
      pick_oh = oh_hi;
    end
`endif
    pick_inc = pick + P_API_BUS_BW'(1);
  end

  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    vld_d     = vld_q;
    bus_d     = bus_q;
    cnt_d     = cnt_q;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    if (nc_reset) begin
      state_d   = ST_IDLE;
      granted_d = '0;
      vld_d     = 1'b0;
      bus_d     = '0;
      cnt_d     = '0;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
      rr_d      = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (nc_transmit) begin
            state_d = ST_ARB;
            cnt_d   = '0;
          end
        end
        ST_ARB: begin
          if (found) begin
            granted_d = pick_oh;
            vld_d     = 1'b1;
            bus_d     = pick_inc;
            if (cnt_q != '1) cnt_d = cnt_q + P_API_BUS_BW'(1);
`ifdef SN_API_ARB_ROUND_ROBIN_EN
            rr_d = (pick_inc == P_API_BUS_BW'(P_NUM_SRC)) ? '0 : pick_inc;
`endif
          end else begin
            granted_d = '0;
            vld_d     = 1'b0;
            bus_d     = '0;
            state_d   = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      granted_q <= '0;
      vld_q     <= 1'b0;
      bus_q     <= '0;
      cnt_q     <= '0;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      vld_q     <= vld_d;
      bus_q     <= bus_d;
      cnt_q     <= cnt_d;
`ifdef SN_API_ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign api_granted  = granted_q;
  assign api_vld      = vld_q;
  assign api_bus      = bus_q;
  assign api_tx_count = cnt_q;
  assign api_busy     = (state_q != ST_IDLE);
  assign api_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sn_api_arbiter.sv
// Randomized self-checking bench for sn_api_arbiter against a phase-level grant-order model.
module tb_sn_api_arbiter;
  localparam int NN = 100;
  localparam int NO = 3;
  localparam int NS = NN - NO;
  localparam int BW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          nc_reset = 1'b0;
  logic          nc_transmit = 1'b0;
  logic [NS-1:0] api_pending = '0;
  logic [NS-1:0] api_granted;
  logic          api_vld;
  logic [BW-1:0] api_bus;
  logic          api_busy;
  logic          api_done;
  logic [BW-1:0] api_tx_count;

  sn_api_arbiter #(.P_NUM_NEURONS(NN), .P_NUM_OUTPUTS(NO)) dut (
    .clk(clk), .rst_n(rst_n), .nc_reset(nc_reset), .nc_transmit(nc_transmit),
    .api_pending(api_pending), .api_granted(api_granted), .api_vld(api_vld),
    .api_bus(api_bus), .api_busy(api_busy), .api_done(api_done),
    .api_tx_count(api_tx_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [NS-1:0] drop_mask = '0;
  logic [NS-1:0] stuck_mask = '0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int model_ptr = 0;
  int cyc_done;
  int inv_errs;
  logic [BW-1:0] cnt_at_done;

  // One clock; sources drop pending one edge after seeing their grant.
  task automatic tick();
    @(posedge clk);
    #1;
    api_pending = api_pending & ~(drop_mask & ~stuck_mask);
    drop_mask = api_granted;
  endtask

  // Model: with a fixed pending set, grants follow circular index order from the pointer.
  task automatic model_phase(input logic [NS-1:0] pend);
    int start;
    int last;
    int k;
    exp_q.delete();
`ifdef SN_API_ARB_ROUND_ROBIN_EN
    start = model_ptr;
`else
    start = 0;
`endif
    last = -1;
    for (int i = 0; i < NS; i++) begin
      k = (start + i) % NS;
      if (pend[k]) begin
        exp_q.push_back(BW'(k + 1));
        last = k;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % NS;
  endtask

  function automatic bit queues_equal();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rand_set(input int n, output logic [NS-1:0] s);
    s = '0;
    while ($countones(s) < n) s[$urandom_range(0, NS - 1)] = 1'b1;
  endtask

  task automatic run_phase(input logic [NS-1:0] pend, input int budget, input int extra_tx);
    logic [NS-1:0] oh;
    obs_q.delete();
    inv_errs = 0;
    cyc_done = -1;
    cnt_at_done = '1;
    api_pending = pend;
    drop_mask = '0;
    nc_transmit = 1'b1;
    tick();
    nc_transmit = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      nc_transmit = (c <= extra_tx);
      tick();
      oh = '0;
      if (api_vld) oh[api_bus - 1'b1] = 1'b1;
      if (api_vld !== (api_granted != '0) || api_vld !== (api_bus != '0) ||
          (api_vld && api_granted !== oh)) inv_errs++;
      if (api_vld) obs_q.push_back(api_bus);
      if (api_done) begin
        cyc_done = c;
        cnt_at_done = api_tx_count;
        break;
      end
    end
    nc_transmit = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (api_granted !== '0 || api_vld !== 1'b0 || api_bus !== '0 || api_busy !== 1'b0 ||
        api_done !== 1'b0 || api_tx_count !== '0) begin
      bad++;
      $display("FAIL reset_values: vld=%b bus=%0d busy=%b done=%b cnt=%0d want all 0",
               api_vld, api_bus, api_busy, api_done, api_tx_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (api_busy !== 1'b0 || api_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b vld=%b want 0 0", api_busy, api_vld);
    end
    // Asynchronous reset during ARB with source 2 granted.
    api_pending = '0;
    api_pending[2] = 1'b1;
    api_pending[10] = 1'b1;
    drop_mask = '0;
    nc_transmit = 1'b1;
    tick();
    nc_transmit = 1'b0;
    tick();
    total++;
    if (api_granted !== NS'(4) || api_vld !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant: granted=%h vld=%b want 4 1", api_granted, api_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (api_granted !== '0 || api_vld !== 1'b0 || api_bus !== '0 || api_busy !== 1'b0 ||
        api_done !== 1'b0 || api_tx_count !== '0) begin
      bad++;
      $display("FAIL reset_async: granted=%h vld=%b bus=%0d busy=%b cnt=%0d want all 0",
               api_granted, api_vld, api_bus, api_busy, api_tx_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    api_pending = '0;
    drop_mask = '0;
    model_ptr = 0;
    tick();
    total++;
    if (api_busy !== 1'b0 || api_vld !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_idle: busy=%b vld=%b want 0 0", api_busy, api_vld);
    end
  endtask

  task automatic test_three();
    logic [NS-1:0] p;
    p = '0;
    p[0] = 1'b1;
    p[5] = 1'b1;
    p[96] = 1'b1;
    model_phase(p);
    run_phase(p, 20, 0);
    total++;
    if (!queues_equal() || obs_q.size() != 3 || obs_q[0] !== BW'(1) || obs_q[2] !== BW'(97)) begin
      bad++;
      $display("FAIL three_order: got %0d grants first=%0d want 1,6,97",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0);
    end
    total++;
    if (cyc_done != 4 || cnt_at_done !== BW'(3) || inv_errs != 0 || api_busy !== 1'b0) begin
      bad++;
      $display("FAIL three_done: done_cycle=%0d cnt=%0d inv=%0d busy=%b want 4 3 0 0",
               cyc_done, cnt_at_done, inv_errs, api_busy);
    end
  endtask

  task automatic test_empty();
    model_phase('0);
    run_phase('0, 10, 0);
    total++;
    if (obs_q.size() != 0 || cyc_done != 1 || cnt_at_done !== '0 || api_busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_phase: vlds=%0d done_cycle=%0d cnt=%0d want 0 1 0",
               obs_q.size(), cyc_done, cnt_at_done);
    end
  endtask

  task automatic test_stuck();
    logic [NS-1:0] p;
    p = '0;
    p[2] = 1'b1;
    stuck_mask = p;
    for (int r = 0; r < 3; r++) begin
      model_phase(p);
      run_phase(p, 10, 0);
      total++;
      if (!queues_equal() || cyc_done != 2 || inv_errs != 0) begin
        bad++;
        $display("FAIL stuck_phase%0d: grants=%0d done_cycle=%0d want one grant of 3 then done at 2",
                 r, obs_q.size(), cyc_done);
      end
    end
    stuck_mask = '0;
    api_pending = '0;
  endtask

  task automatic test_fairness();
    logic [NS-1:0] p;
    logic [BW-1:0] first10[$];
    int c;
    nc_reset = 1'b1;
    tick();
    nc_reset = 1'b0;
    model_ptr = 0;
    model_phase('1);
    first10 = exp_q[0:9];
    obs_q.delete();
    api_pending = '1;
    drop_mask = '0;
    nc_transmit = 1'b1;
    tick();
    nc_transmit = 1'b0;
    c = 0;
    while (obs_q.size() < 10 && c < 30) begin
      tick();
      if (api_vld) obs_q.push_back(api_bus);
      c++;
    end
    nc_reset = 1'b1;
    tick();
    nc_reset = 1'b0;
    api_pending = '0;
    drop_mask = '0;
    model_ptr = 0;
    exp_q = first10;
    total++;
    if (!queues_equal() || exp_q[9] !== BW'(10)) begin
      bad++;
      $display("FAIL fair_first10: got %0d grants last=%0d want 1..10",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : 0);
    end
    total++;
    if (api_vld !== 1'b0 || api_busy !== 1'b0 || api_tx_count !== '0 || api_done !== 1'b0) begin
      bad++;
      $display("FAIL fair_nc_reset: vld=%b busy=%b cnt=%0d done=%b want 0 0 0 0",
               api_vld, api_busy, api_tx_count, api_done);
    end
    tick();
    p = '0;
    p[0] = 1'b1;
    p[20] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      model_phase(p);
      run_phase(p, 10, 0);
      total++;
      if (!queues_equal() || obs_q[0] !== BW'(1) || obs_q[1] !== BW'(21) || cyc_done != 3) begin
        bad++;
        $display("FAIL fair_pair%0d: grants=%0d first=%0d want 1 then 21",
                 r, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 0);
      end
    end
  endtask

  task automatic test_tx_ignored();
    logic [NS-1:0] p;
    rand_set(10, p);
    model_phase(p);
    run_phase(p, 40, 3);
    total++;
    if (!queues_equal() || cyc_done != 11 || cnt_at_done !== BW'(10) || api_busy !== 1'b0) begin
      bad++;
      $display("FAIL tx_ignored: grants=%0d done_cycle=%0d cnt=%0d busy=%b want 10 11 10 0",
               obs_q.size(), cyc_done, cnt_at_done, api_busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [NS-1:0] p;
    int c;
    int done_hits;
    rand_set(10, p);
    model_phase(p);
    obs_q.delete();
    api_pending = p;
    drop_mask = '0;
    nc_transmit = 1'b1;
    tick();
    nc_transmit = 1'b0;
    c = 0;
    while (obs_q.size() < 4 && c < 20) begin
      tick();
      if (api_vld) obs_q.push_back(api_bus);
      c++;
    end
    nc_reset = 1'b1;
    tick();
    nc_reset = 1'b0;
    model_ptr = 0;
    total++;
    if (obs_q.size() != 4 || obs_q[3] !== exp_q[3]) begin
      bad++;
      $display("FAIL midrst_grants: got %0d grants want first 4 of model", obs_q.size());
    end
    total++;
    if (api_busy !== 1'b0 || api_vld !== 1'b0 || api_tx_count !== '0 || api_done !== 1'b0 ||
        api_granted !== '0) begin
      bad++;
      $display("FAIL midrst_state: busy=%b vld=%b cnt=%0d done=%b want 0 0 0 0",
               api_busy, api_vld, api_tx_count, api_done);
    end
    done_hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (api_done || api_vld) done_hits++;
    end
    total++;
    if (done_hits != 0) begin
      bad++;
      $display("FAIL midrst_no_done: done/vld cycles=%0d want 0", done_hits);
    end
    api_pending = '0;
    drop_mask = '0;
  endtask

  task automatic test_random();
    logic [NS-1:0] p;
    for (int r = 0; r < 8; r++) begin
      rand_set($urandom_range(0, 12), p);
      model_phase(p);
      run_phase(p, 40, 0);
      total++;
      if (!queues_equal() || cyc_done != exp_q.size() + 1 ||
          cnt_at_done !== BW'(exp_q.size()) || inv_errs != 0) begin
        bad++;
        $display("FAIL random%0d: grants=%0d want %0d done_cycle=%0d cnt=%0d inv=%0d",
                 r, obs_q.size(), exp_q.size(), cyc_done, cnt_at_done, inv_errs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_empty();
    test_stuck();
    test_fairness();
    test_tx_ignored();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sn_api_arbiter.md
# sn_api_arbiter

Axon Protocol Interface (API) bus arbiter for the spiking network core. During each transmit phase it collects `api_pending` requests from every non-output neuron. It grants the shared bus to one neuron per cycle and drives `api_vld` plus the 1-based source index onto `api_bus`, which hidden and output neurons consume. When no requests remain it reports phase completion to the network controller, which then issues `nc_evaluate`.

## Interface
Parameters:
- `P_NUM_NEURONS`, 100, total neurons in the network.
- `P_NUM_OUTPUTS`, 3, output-layer neurons. These never transmit.
- `P_NUM_SRC`, `P_NUM_NEURONS-P_NUM_OUTPUTS`, number of requesting sources.
- `P_API_BUS_BW`, `$clog2(P_NUM_SRC+1)`, width of the bus index. Index 0 is reserved as idle.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `nc_reset`  in  1  synchronous clear from the network controller.
- `nc_transmit`  in  1  pulse that starts a transmit phase.
- `api_pending`  in  `P_NUM_SRC`  request vector. Bit k belongs to neuron index k+1.
- `api_granted`  out  `P_NUM_SRC`  one-hot grant, registered.
- `api_vld`  out  1  bus-valid, registered.
- `api_bus`  out  `P_API_BUS_BW`  granted source index (k+1) while `api_vld` is high, else 0.
- `api_busy`  out  1  high while a transmit phase is in progress.
- `api_done`  out  1  one-cycle pulse at the end of a phase.
- `api_tx_count`  out  `P_API_BUS_BW`  number of grants issued in the current or most recent phase.

## Operation
- **States:**
  - IDLE: `api_busy`=0.
  - ARB: `api_busy`=1.
  - DONE: `api_busy`=1, `api_done`=1.
- **IDLE → ARB:** on the edge that samples `nc_transmit`=1. The same edge clears `api_tx_count` to 0. No grant is issued on this edge.
- **ARB, each edge:**
  - Compute `eligible = api_pending & ~api_granted`. The previous-cycle grant is masked because the source drops `pending` one edge after seeing its grant.
  - If `eligible`≠0: pick one bit k, register `api_granted`=1<<k, `api_vld`=1, `api_bus`=k+1, and increment `api_tx_count`.
  - If `eligible`=0: clear grant, vld and bus, then go to DONE.
- **DONE → IDLE:** unconditionally on the next edge.
- **`nc_transmit` outside IDLE:** ignored. It is not queued.
- **Requests raised mid-phase:** granted if they become eligible before the phase empties. Once DONE is reached, they wait for the next phase.
- **Selection:** round-robin or fixed priority; see Configuration.
  - The round-robin pointer `rr_ptr` is set to k+1 (mod `P_NUM_SRC`) after each grant.
  - The search starts at `rr_ptr` and wraps past `P_NUM_SRC-1` to 0.
  - `rr_ptr` persists across phases.
- **`api_tx_count`:** saturates at its maximum value and never wraps. It holds its value through IDLE until the next `nc_transmit`.
- **`nc_reset`:** synchronous; takes priority over `nc_transmit`. It returns the block to IDLE and clears grant, vld, bus, count and `rr_ptr` on the next edge. This applies mid-phase too, and no DONE pulse is produced.

## Timing
- **Reset values** (`rst_n`=0, asynchronous): state IDLE.
  - `api_granted`=0, `api_vld`=0, `api_bus`=0, `api_busy`=0, `api_done`=0, `api_tx_count`=0, `rr_ptr`=0.
- **Latency:** with `nc_transmit` sampled at edge E, the first `api_vld` is high in the cycle following edge E+1.
- **Throughput:** one grant per cycle, back-to-back.
  - Exception: the same source is never granted in two consecutive cycles, even if it keeps `pending` high.
- **Phase length:** N sources pending at phase start produce N consecutive `api_vld` cycles. `api_done` is high in the cycle after the last vld cycle.
- **Empty phase:** with no requests, `api_done` pulses in the cycle after edge E+1, with zero vld cycles.
- **Output constraints:** all outputs are registered, with no combinational path from `api_pending` to any output. `api_vld`=1 ⇔ `api_granted`≠0 ⇔ `api_bus`≠0.

## Configuration
- **`SN_API_ARB_ROUND_ROBIN_EN` defined:** round-robin selection using `rr_ptr`, as described under Operation.
- **Undefined:** fixed priority, lowest k first. `rr_ptr` is not implemented. All other behaviour and timing are identical.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-cycle during ARB with `api_granted`=0x4 → all outputs 0 immediately. After release, IDLE with `api_busy`=0.
- **Three sources:** sources 0, 5 and 96 pending, each dropping `pending` one edge after its grant, then `nc_transmit` pulse.
  - `api_bus` sequence 1, 6, 97 on consecutive cycles.
  - `api_done` pulses on the next cycle; `api_tx_count`=3.
- **Stuck request:** source 2 holds `pending`=1 forever → `api_bus`=3 is never granted on two consecutive cycles. With no other pending sources, grants alternate with DONE.
- **Round-robin fairness** (macro defined): all 97 sources pending in phase 1, stopped by `nc_reset` after 10 grants, which clears `rr_ptr`.
  - Phase 1 grants `api_bus`=1..10.
  - In a new phase with only sources 0 and 20 pending, the order is 1 then 21.
  - Without the macro, the order is also 1, 21. After a re-pend of both, the order is again 1, 21.
- **Empty phase:** `nc_transmit` with `api_pending`=0 → zero vld cycles. `api_done` appears 2 cycles after the `nc_transmit` edge; `api_tx_count`=0.
- **Mid-phase reset:** `nc_reset` pulse during the 4th grant of a 10-source phase.
  - Next cycle: IDLE, `api_vld`=0, `api_tx_count`=0, and no `api_done` pulse.
  - A second `nc_transmit` asserted during ARB is ignored, and the phase length is unchanged.
